// File: rtl/clk_gate_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_gating_pkg
// Description : Shared state type and defaults for the clock-gating controller.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_gating_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        OFF  = 2'd1,
        WAKE = 2'd2
    } cg_state_t;

    localparam int C_DEFAULT_IDLE_CYCLES = 8;
    localparam int C_DEFAULT_WAKE_CYCLES = 2;

    // One counter serves both phases, so size it for the longer of the two.
    function automatic int cnt_width(input int idle_cycles, input int wake_cycles);
        int max_v;
        max_v = (idle_cycles > wake_cycles) ? idle_cycles : wake_cycles;
        return $clog2(max_v + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_gate_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : clk_gate_ctrl_if
// Description : Activity/wake handshake and gate status bundle.
//               Carries force_on when CLK_GATE_CTRL_FORCE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface clk_gate_ctrl_if;

    logic busy;
    logic wake_req;
    logic gate_en;
    logic wake_ack;
    logic gated;
`ifdef CLK_GATE_CTRL_FORCE_EN
    logic force_on;
`endif

`ifdef CLK_GATE_CTRL_FORCE_EN
    modport master (
        output busy,
        output wake_req,
        output force_on,
        input  gate_en,
        input  wake_ack,
        input  gated
    );

    modport slave (
        input  busy,
        input  wake_req,
        input  force_on,
        output gate_en,
        output wake_ack,
        output gated
    );
`else
    modport master (
        output busy,
        output wake_req,
        input  gate_en,
        input  wake_ack,
        input  gated
    );

    modport slave (
        input  busy,
        input  wake_req,
        output gate_en,
        output wake_ack,
        output gated
    );
`endif

endinterface
`default_nettype wire

// File: rtl/clk_gate_ctrl_cnt.sv
`default_nettype none
// ============================================================================
// Module      : clk_gate_cnt
// Description : Clearable saturating up-counter with terminal-count compare.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_gate_cnt #(
    parameter int WIDTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             clr_i,
    input  wire logic             inc_i,
    input  wire logic [WIDTH-1:0] term_i,
    output logic                  tc_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == term_i);

endmodule
`default_nettype wire

// File: rtl/clk_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clk_gate_ctrl
// Description : Enable-side controller for the clock-gating cell: gates after
//               an idle run, restores the clock on request and acknowledges.
//               Optional force_on input via CLK_GATE_CTRL_FORCE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_gate_ctrl
    import clk_gating_pkg::*;
#(
    parameter int IDLE_CYCLES = C_DEFAULT_IDLE_CYCLES,
    parameter int WAKE_CYCLES = C_DEFAULT_WAKE_CYCLES
) (
    input  wire logic       clk,
    input  wire logic       rst,
    clk_gate_ctrl_if.slave  cg
);

    localparam int CNT_W = cnt_width(IDLE_CYCLES, WAKE_CYCLES);
    localparam logic [CNT_W-1:0] C_IDLE_TERM = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_WAKE_TERM = CNT_W'(WAKE_CYCLES - 1);

    if (IDLE_CYCLES < 1) begin : g_bad_idle
        $error("clk_gate_ctrl: IDLE_CYCLES must be at least 1");
    end
    if (WAKE_CYCLES < 1) begin : g_bad_wake
        $error("clk_gate_ctrl: WAKE_CYCLES must be at least 1");
    end

    cg_state_t        state_q;
    cg_state_t        state_d;
    logic             gate_en_q;
    logic             gate_en_d;
    logic             wake_ack_q;
    logic             wake_ack_d;
    logic             gated_q;
    logic             gated_d;

    logic             w_clr;
    logic             w_inc;
    logic [CNT_W-1:0] w_term;
    logic             w_tc;
    logic             w_idle;
    logic             w_force;

`ifdef CLK_GATE_CTRL_FORCE_EN
    assign w_force = cg.force_on;
`else
    assign w_force = 1'b0;
`endif

    assign w_idle = !cg.busy && !cg.wake_req;

    clk_gate_cnt #(
        .WIDTH (CNT_W)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (w_clr),
        .inc_i  (w_inc),
        .term_i (w_term),
        .tc_o   (w_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            gate_en_q  <= 1'b1;
            wake_ack_q <= 1'b0;
            gated_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_en_q  <= gate_en_d;
            wake_ack_q <= wake_ack_d;
            gated_q    <= gated_d;
        end
    end

    // Every state change clears the shared counter so each phase starts at 0.
    always_comb begin
        state_d = state_q;
        w_clr   = 1'b0;
        w_inc   = 1'b0;
        w_term  = C_IDLE_TERM;
        case (state_q)
            RUN: begin
                if (w_force || !w_idle) begin
                    w_clr = 1'b1;
                end else if (w_tc) begin
                    state_d = OFF;
                    w_clr   = 1'b1;
                end else begin
                    w_inc = 1'b1;
                end
            end
            OFF: begin
                if (cg.busy || cg.wake_req || w_force) begin
                    state_d = WAKE;
                    w_clr   = 1'b1;
                end
            end
            WAKE: begin
                w_term = C_WAKE_TERM;
                if (w_tc) begin
                    state_d = RUN;
                    w_clr   = 1'b1;
                end else begin
                    w_inc = 1'b1;
                end
            end
            default: begin
                state_d = RUN;
                w_clr   = 1'b1;
            end
        endcase
    end

    always_comb begin
        gate_en_d  = (state_d != OFF);
        gated_d    = (state_d == OFF);
        wake_ack_d = (state_d == RUN) && cg.wake_req;
    end

    assign cg.gate_en  = gate_en_q;
    assign cg.wake_ack = wake_ack_q;
    assign cg.gated    = gated_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_gate_ctrl
// Description : Scoreboard bench for clk_gate_ctrl (IDLE_CYCLES=4, WAKE_CYCLES=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_gate_ctrl;

    localparam int C_IDLE = 4;
    localparam int C_WAKE = 2;

    typedef struct {
        logic  ge;
        logic  ack;
        logic  gd;
        int    cnt;
        string tag;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb[$];
    int   vectors;
    int   miscompares;

    // Reference model: phase name plus cycles spent in the phase.
    string m_mode;
    int    m_cnt;
    bit    m_ack;

    clk_gate_ctrl_if ifc ();

    clk_gate_ctrl #(
        .IDLE_CYCLES (C_IDLE),
        .WAKE_CYCLES (C_WAKE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .cg  (ifc.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void model(input bit r, input bit b, input bit w, input bit f);
        if (r) begin
            m_mode = "RUN";
            m_cnt  = 0;
            m_ack  = 0;
            return;
        end
        if (m_mode == "RUN") begin
            if (f || b || w) m_cnt = 0;
            else if (m_cnt + 1 == C_IDLE) begin
                m_mode = "OFF";
                m_cnt  = 0;
            end else m_cnt++;
        end else if (m_mode == "OFF") begin
            if (b || w || f) begin
                m_mode = "WAKE";
                m_cnt  = 0;
            end
        end else begin
            if (m_cnt + 1 == C_WAKE) begin
                m_mode = "RUN";
                m_cnt  = 0;
            end else m_cnt++;
        end
        m_ack = (m_mode == "RUN") && w;
    endfunction

    task automatic drive(input bit r, input bit b, input bit w, input bit f, input string tag);
        exp_t e;
        @(negedge clk);
        rst          = r;
        ifc.busy     = b;
        ifc.wake_req = w;
`ifdef CLK_GATE_CTRL_FORCE_EN
        ifc.force_on = f;
`endif
        model(r, b, w, f);
        e.ge  = (m_mode != "OFF");
        e.gd  = (m_mode == "OFF");
        e.ack = m_ack;
        e.cnt = m_cnt;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    // Four-phase request: hold until ack, then release and let ack fall.
    task automatic request(input string tag);
        int k;
        k = 0;
        drive(1'b0, 1'b0, 1'b1, 1'b0, tag);
        while (!m_ack && k < 20) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, tag);
            k++;
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, tag);
        drive(1'b0, 1'b0, 1'b0, 1'b0, tag);
        drive(1'b0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    initial begin : monitor
        exp_t e;
        int   act_cnt;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                act_cnt = int'(dut.u_cnt.cnt_q);
                if (ifc.gate_en !== e.ge || ifc.wake_ack !== e.ack ||
                    ifc.gated !== e.gd || act_cnt != e.cnt) begin
                    miscompares++;
                    $display("FAIL %s @%0t: got gate_en=%b wake_ack=%b gated=%b cnt=%0d, want gate_en=%b wake_ack=%b gated=%b cnt=%0d",
                             e.tag, $time, ifc.gate_en, ifc.wake_ack, ifc.gated, act_cnt,
                             e.ge, e.ack, e.gd, e.cnt);
                end
            end
        end
    end

    initial begin : stim
        bit rq;
        bit rb;
        bit rr;
        bit rf;
        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b1;
        ifc.busy     = 1'b0;
        ifc.wake_req = 1'b0;
`ifdef CLK_GATE_CTRL_FORCE_EN
        ifc.force_on = 1'b0;
`endif
        m_mode = "RUN";
        m_cnt  = 0;
        m_ack  = 0;

        // Reset release into an idle run, then gated.
        drive(1'b1, 1'b0, 1'b0, 1'b0, "s1_reset");
        drive(1'b1, 1'b0, 1'b0, 1'b0, "s1_reset");
        idle(8, "s1_gate_off");

        // Periodic activity keeps the clock running.
        drive(1'b1, 1'b0, 1'b0, 1'b0, "s2_reset");
        for (int i = 0; i < 12; i++) drive(1'b0, (i % 3) == 2, 1'b0, 1'b0, "s2_busy_pulse");

        // Wake from OFF with the full handshake.
        idle(6, "s3_to_off");
        request("s3_wake");

        // Activity on the terminal idle cycle.
        drive(1'b1, 1'b0, 1'b0, 1'b0, "s4_reset");
        idle(3, "s4_idle");
        drive(1'b0, 1'b1, 1'b0, 1'b0, "s4_busy_term");
        idle(2, "s4_after");

        // Reset during WAKE, then a request dropped mid-WAKE.
        idle(6, "s5_to_off");
        drive(1'b0, 1'b0, 1'b1, 1'b0, "s5_wake");
        drive(1'b1, 1'b0, 1'b1, 1'b0, "s5_rst_wake");
        drive(1'b0, 1'b0, 1'b0, 1'b0, "s5_post_rst");
        idle(6, "s5_to_off2");
        drive(1'b0, 1'b0, 1'b1, 1'b0, "s5_wake2");
        drive(1'b0, 1'b0, 1'b0, 1'b0, "s5_drop");
        idle(3, "s5_no_ack");

        // Request while running: ack on the next edge.
        drive(1'b1, 1'b0, 1'b0, 1'b0, "s7_reset");
        idle(2, "s7_idle");
        request("s7_run_req");

`ifdef CLK_GATE_CTRL_FORCE_EN
        drive(1'b1, 1'b0, 1'b0, 1'b0, "s6_reset");
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, "s6_force");
        idle(6, "s6_release");
        drive(1'b0, 1'b0, 1'b0, 1'b1, "s6_force_off");
        drive(1'b0, 1'b0, 1'b0, 1'b0, "s6_wake");
        idle(2, "s6_run");
`endif

        // Randomised traffic with a well-behaved (mostly) requester.
        rq = 1'b0;
        for (int i = 0; i < 600; i++) begin
            rb = ($urandom_range(0, 9) == 0);
            rr = ($urandom_range(0, 199) == 0);
`ifdef CLK_GATE_CTRL_FORCE_EN
            rf = ($urandom_range(0, 29) == 0);
`else
            rf = 1'b0;
`endif
            if (!rq) rq = ($urandom_range(0, 11) == 0);
            else if (m_ack) rq = ($urandom_range(0, 1) == 0);
            else if ($urandom_range(0, 15) == 0) rq = 1'b0;
            drive(rr, rb, rq, rf, "rand");
        end

        @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
